// File: rtl/voicemail_manager_if.sv
// Command and CF sector bus between the user interface and the voicemail manager.
interface voicemail_manager_if #(
    parameter int NUM_BOXES = 4,
    parameter int SLOTS     = 8,
    parameter int SECT_W    = 24
);
    localparam int BOX_W  = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W  = $clog2(SLOTS + 1);

    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [BOX_W-1:0]  box_sel;
    logic              card_present;
    logic              cf_ack;
    logic              cmd_ready;
    logic              cf_req;
    logic              cf_write;
    logic [SECT_W-1:0] cf_sector;
    logic [2:0]        state;
    logic [CNT_W-1:0]  sel_count;
    logic [SLOT_W-1:0] play_slot;
    logic              err;

    modport slave (
        input  cmd_valid, cmd, box_sel, card_present, cf_ack,
        output cmd_ready, cf_req, cf_write, cf_sector, state, sel_count, play_slot, err
    );

    modport master (
        output cmd_valid, cmd, box_sel, card_present, cf_ack,
        input  cmd_ready, cf_req, cf_write, cf_sector, state, sel_count, play_slot, err
    );
endinterface

// File: rtl/voicemail_manager.sv
// Multi-mailbox voicemail controller: allocates fixed CF slots per message,
// sequences sector read/write requests and tracks occupancy, lengths and play pointers.
module voicemail_manager #(
    parameter int NUM_BOXES        = 4,
    parameter int SLOTS            = 8,
    parameter int SECTORS_PER_SLOT = 256,
    parameter int SECT_W           = 24
) (
    input logic clk,
    input logic reset,
    voicemail_manager_if.slave bus
);
    localparam int BOX_W  = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W  = $clog2(SLOTS + 1);
    localparam int LEN_W  = $clog2(SECTORS_PER_SLOT + 1);

    typedef enum logic [2:0] {NOCARD = 3'd0, IDLE = 3'd1, REC = 3'd2, PLAY = 3'd3} state_t;
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_REC = 3'd1, CMD_STOP = 3'd2,
        CMD_PLAY = 3'd3, CMD_DEL = 3'd4, CMD_NEXT = 3'd5
    } cmd_t;

    state_t            fsm;
    logic [SLOTS-1:0]  occ [NUM_BOXES];
    logic [LEN_W-1:0]  len [NUM_BOXES][SLOTS];
    logic [SLOT_W-1:0] ptr [NUM_BOXES];
    logic [BOX_W-1:0]  cur_box;
    logic [SLOT_W-1:0] cur_slot;
    logic [LEN_W-1:0]  offset;
    logic              cf_req_r;
    logic              cf_write_r;
    logic [SECT_W-1:0] cf_sector_r;
    logic              err_r;

    logic              box_ok;
    logic [BOX_W-1:0]  box_idx;
    logic              free_found;
    logic [SLOT_W-1:0] free_slot;
    logic              next_found;
    logic [SLOT_W-1:0] next_slot;
    logic [CNT_W-1:0]  cnt;
    logic              ack;
    logic              stop;
    logic              last_rec;
    logic              last_play;
    logic [LEN_W-1:0]  rec_len;

    function automatic logic [SECT_W-1:0] slot_base(logic [BOX_W-1:0] b, logic [SLOT_W-1:0] s);
        return SECT_W'((int'(b) * SLOTS + int'(s)) * SECTORS_PER_SLOT);
    endfunction

    assign box_ok    = int'(bus.box_sel) < NUM_BOXES;
    assign box_idx   = box_ok ? bus.box_sel : '0;
    assign ack       = cf_req_r & bus.cf_ack;
    assign stop      = bus.cmd_valid && (bus.cmd == CMD_STOP);
    assign rec_len   = offset + LEN_W'(ack);
    assign last_rec  = ack && (offset == LEN_W'(SECTORS_PER_SLOT - 1));
    assign last_play = ack && ((offset + LEN_W'(1)) == len[cur_box][cur_slot]);

    // Per-box lookups for the selected mailbox: lowest free slot, next occupied slot, count
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        next_found = 1'b0;
        next_slot  = ptr[box_idx];
        cnt        = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!free_found && !occ[box_idx][i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
            cnt = cnt + CNT_W'(occ[box_idx][i]);
        end
        for (int unsigned i = 1; i < SLOTS; i++) begin
            if (!next_found && occ[box_idx][SLOT_W'((32'(ptr[box_idx]) + i) % SLOTS)]) begin
                next_found = 1'b1;
                next_slot  = SLOT_W'((32'(ptr[box_idx]) + i) % SLOTS);
            end
        end
    end

    assign bus.cmd_ready = (fsm != NOCARD);
    assign bus.cf_req    = cf_req_r;
    assign bus.cf_write  = cf_write_r;
    assign bus.cf_sector = cf_sector_r;
    assign bus.state     = fsm;
    assign bus.sel_count = box_ok ? cnt : '0;
    assign bus.play_slot = ptr[box_idx];
    assign bus.err       = err_r;

    // Controller FSM together with the mailbox bookkeeping it owns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm         <= NOCARD;
            cur_box     <= '0;
            cur_slot    <= '0;
            offset      <= '0;
            cf_req_r    <= 1'b0;
            cf_write_r  <= 1'b0;
            cf_sector_r <= '0;
            err_r       <= 1'b0;
            for (int unsigned b = 0; b < NUM_BOXES; b++) begin
                occ[b] <= '0;
                ptr[b] <= '0;
                for (int unsigned s = 0; s < SLOTS; s++) len[b][s] <= '0;
            end
        end else begin
            err_r <= 1'b0;
            // Card removal overrides everything; an unfinished recording never sets its bit
            if (fsm != NOCARD && !bus.card_present) begin
                fsm        <= NOCARD;
                cf_req_r   <= 1'b0;
                cf_write_r <= 1'b0;
            end else begin
                case (fsm)
                    NOCARD: if (bus.card_present) fsm <= IDLE;
                    IDLE: if (bus.cmd_valid) begin
                        case (bus.cmd)
                            CMD_NOP, CMD_STOP: ;
                            CMD_REC: if (!box_ok || !free_found) err_r <= 1'b1;
                            else begin
                                fsm         <= REC;
                                cur_box     <= bus.box_sel;
                                cur_slot    <= free_slot;
                                offset      <= '0;
                                cf_req_r    <= 1'b1;
                                cf_write_r  <= 1'b1;
                                cf_sector_r <= slot_base(bus.box_sel, free_slot);
                            end
                            CMD_PLAY: if (!box_ok || !occ[box_idx][ptr[box_idx]]) err_r <= 1'b1;
                            else begin
                                fsm         <= PLAY;
                                cur_box     <= bus.box_sel;
                                cur_slot    <= ptr[box_idx];
                                offset      <= '0;
                                cf_req_r    <= 1'b1;
                                cf_write_r  <= 1'b0;
                                cf_sector_r <= slot_base(bus.box_sel, ptr[box_idx]);
                            end
                            CMD_DEL: if (!box_ok || !occ[box_idx][ptr[box_idx]]) err_r <= 1'b1;
                            else occ[box_idx][ptr[box_idx]] <= 1'b0;
                            CMD_NEXT: if (!box_ok) err_r <= 1'b1;
                            else ptr[box_idx] <= next_slot;
                            default: err_r <= 1'b1;
                        endcase
                    end
                    REC, PLAY: begin
                        if (bus.cmd_valid && bus.cmd != CMD_STOP && bus.cmd != CMD_NOP)
                            err_r <= 1'b1;
                        // An ack arriving with STOP is folded into the length before finishing
                        if (fsm == REC && (stop || last_rec)) begin
                            len[cur_box][cur_slot] <= rec_len;
                            if (rec_len != '0) occ[cur_box][cur_slot] <= 1'b1;
                            ptr[cur_box] <= cur_slot;
                            fsm          <= IDLE;
                            cf_req_r     <= 1'b0;
                            cf_write_r   <= 1'b0;
                        end else if (fsm == PLAY && (stop || last_play)) begin
                            fsm      <= IDLE;
                            cf_req_r <= 1'b0;
                        end else if (ack) begin
                            offset      <= offset + LEN_W'(1);
                            cf_sector_r <= cf_sector_r + SECT_W'(1);
                            cf_req_r    <= 1'b0;
                        end else if (!cf_req_r) begin
                            cf_req_r <= 1'b1;
                        end
                    end
                    default: fsm <= NOCARD;
                endcase
            end
        end
    end
endmodule
